// File: rtl/game_pkg.sv
// Shared game-control definitions: FSM encodings, difficulty tiers, lane count
// and the score-to-tick-period mapping used by the lane scheduler.
package game_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned TICK_W    = 20;
   localparam int unsigned PAUSE_W   = 25;
   localparam int unsigned DIV_W     = 3;

   // Lowest-difficulty tick period in clocks.
   localparam logic [TICK_W-1:0] C_BASE_TICK_DEF = 20'd781250;

   // Highest score of each of the first three tiers; above the last tier the
   // fastest rate applies.
   localparam logic [3:0] SCORE_TIER_1 = 4'd3;
   localparam logic [3:0] SCORE_TIER_2 = 4'd6;
   localparam logic [3:0] SCORE_TIER_3 = 4'd9;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StHit   = 2'd2,
      StLevel = 2'd3
   } state_e;

   // Tick period halves at each score tier.
   function automatic logic [TICK_W-1:0] tick_period(input logic [TICK_W-1:0] base,
                                                     input logic [3:0]        score);
      logic [TICK_W-1:0] period;
      if (score <= SCORE_TIER_1) begin
         period = base;
      end else if (score <= SCORE_TIER_2) begin
         period = base >> 1;
      end else if (score <= SCORE_TIER_3) begin
         period = base >> 2;
      end else begin
         period = base >> 3;
      end
      return period;
   endfunction

endpackage

// File: rtl/lane_divider.sv
// Per-lane tick divider: counts scheduler ticks and emits a registered
// one-cycle step every DIV ticks.
module lane_divider
   import game_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Clear,
   input  logic i_Tick,
   output logic o_Step
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] cnt_q;
   logic             step_q;

   // Count ticks; the step lands one clock after the tick that completes a period.
   always_ff @(posedge i_Clk) begin
      if (i_Reset || i_Clear) begin
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else if (i_Tick) begin
         if (cnt_q == LAST) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
            step_q <= 1'b0;
         end
      end else begin
         step_q <= 1'b0;
      end
   end

   assign o_Step = step_q;

endmodule

// File: rtl/lane_scheduler.sv
// Obstacle-lane timing controller: derives a score-scaled tick, divides it per
// lane into step enables, owns lane directions, and sequences the freeze and
// reload windows after a collision or level-up.
module lane_scheduler
   import game_pkg::*;
#(
   parameter logic [TICK_W-1:0]    C_BASE_TICK    = C_BASE_TICK_DEF,
   parameter int unsigned          C_DIV_0        = 2,
   parameter int unsigned          C_DIV_1        = 1,
   parameter int unsigned          C_DIV_2        = 2,
   parameter int unsigned          C_DIV_3        = 4,
   parameter logic [PAUSE_W-1:0]   C_PAUSE_CYCLES = 25'd25000000,
   parameter logic [NUM_LANES-1:0] C_REVERSE_INIT = 4'b1010
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_Start,
   input  logic [3:0]           i_Score,
   input  logic                 i_Collision,
   input  logic                 i_Level_Up,
   output logic [NUM_LANES-1:0] o_Step,
   output logic [NUM_LANES-1:0] o_Reverse,
   output logic                 o_Freeze,
   output logic                 o_Load_Init,
   output logic [1:0]           o_State
);

   localparam logic [PAUSE_W-1:0] PAUSE_LAST = C_PAUSE_CYCLES - 25'd1;

   state_e               state_q, state_d;
   logic [TICK_W-1:0]    tick_cnt_q;
   logic [TICK_W-1:0]    period;
   logic [TICK_W-1:0]    period_m1;
   logic [PAUSE_W-1:0]   pause_cnt_q;
   logic [NUM_LANES-1:0] reverse_q;
   logic                 load_init_q;

   logic                 in_run;
   logic                 in_pause;
   logic                 enter_pause;
   logic                 rotate;
   logic                 tick;
   logic                 pause_done;
   logic                 enter_run;
   logic                 clear_lanes;
   logic [NUM_LANES-1:0] step;

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: collision outranks level-up; pauses end on the last pause clock.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (i_Start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (i_Collision) begin
               state_d = StHit;
            end else if (i_Level_Up) begin
               state_d = StLevel;
            end
         end
         StHit, StLevel: begin
            if (pause_done) begin
               state_d = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output and control decode from the current state and event inputs.
   always_comb begin
      in_run      = (state_q == StRun);
      in_pause    = (state_q == StHit) || (state_q == StLevel);
      enter_pause = in_run && (i_Collision || i_Level_Up);
      rotate      = in_run && !i_Collision && i_Level_Up;
      pause_done  = in_pause && (pause_cnt_q == PAUSE_LAST);
      enter_run   = (state_d == StRun) && !in_run;
      // Compare with >= so a mid-count score rise fires at once instead of wrapping.
      tick        = in_run && !enter_pause && (tick_cnt_q >= period_m1);
      clear_lanes = !in_run || enter_pause;
      o_Freeze    = !in_run;
      o_State     = state_q;
   end

   // Score-dependent tick period; a degenerate zero period behaves as one clock.
   always_comb begin
      period    = tick_period(C_BASE_TICK, i_Score);
      period_m1 = (period == '0) ? '0 : period - 20'd1;
   end

   // Tick and pause counters, lane directions and the reload pulse.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         tick_cnt_q  <= '0;
         pause_cnt_q <= '0;
         reverse_q   <= C_REVERSE_INIT;
         load_init_q <= 1'b0;
      end else begin
         load_init_q <= enter_run;

         if (!in_run || enter_pause || tick) begin
            tick_cnt_q <= '0;
         end else begin
            tick_cnt_q <= tick_cnt_q + 20'd1;
         end

         if (in_pause && !pause_done) begin
            pause_cnt_q <= pause_cnt_q + 25'd1;
         end else begin
            pause_cnt_q <= '0;
         end

         if (rotate) begin
            reverse_q <= {reverse_q[NUM_LANES-2:0], reverse_q[NUM_LANES-1]};
         end
      end
   end

   lane_divider #(
      .DIV (C_DIV_0)
   ) u_lane_0 (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clear (clear_lanes),
      .i_Tick  (tick),
      .o_Step  (step[0])
   );

   lane_divider #(
      .DIV (C_DIV_1)
   ) u_lane_1 (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clear (clear_lanes),
      .i_Tick  (tick),
      .o_Step  (step[1])
   );

   lane_divider #(
      .DIV (C_DIV_2)
   ) u_lane_2 (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clear (clear_lanes),
      .i_Tick  (tick),
      .o_Step  (step[2])
   );

   lane_divider #(
      .DIV (C_DIV_3)
   ) u_lane_3 (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clear (clear_lanes),
      .i_Tick  (tick),
      .o_Step  (step[3])
   );

   assign o_Step      = step;
   assign o_Reverse   = reverse_q;
   assign o_Load_Init = load_init_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with a 16-clock base tick and 8-clock pause.
module tb_lane_scheduler;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_Start;
   logic [3:0] i_Score;
   logic       i_Collision;
   logic       i_Level_Up;
   logic [3:0] o_Step;
   logic [3:0] o_Reverse;
   logic       o_Freeze;
   logic       o_Load_Init;
   logic [1:0] o_State;

   int total = 0;
   int bad   = 0;

   // Expected step pattern for the clocks after the score jump.
   logic [3:0] exp_seq [6] = '{4'b0000, 4'b0111, 4'b0000, 4'b0010, 4'b0000, 4'b1111};
   // Score tier table: score applied right after a step, expected gap to the next step.
   int         gap_score [8] = '{3, 4, 6, 7, 9, 10, 15, 0};
   int         gap_exp   [8] = '{16, 8, 8, 4, 4, 2, 2, 16};

   always #5 i_Clk = ~i_Clk;

   lane_scheduler #(
      .C_BASE_TICK    (20'd16),
      .C_PAUSE_CYCLES (25'd8)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Start     (i_Start),
      .i_Score     (i_Score),
      .i_Collision (i_Collision),
      .i_Level_Up  (i_Level_Up),
      .o_Step      (o_Step),
      .o_Reverse   (o_Reverse),
      .o_Freeze    (o_Freeze),
      .o_Load_Init (o_Load_Init),
      .o_State     (o_State)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_clk();
      @(posedge i_Clk);
      #1;
   endtask

   // Clocks until the next lane-1 step; 0 when none shows within the bound.
   task automatic measure_gap(output int gap);
      gap = 0;
      for (int c = 1; c <= 100; c++) begin
         next_clk();
         if (o_Step[1]) begin
            gap = c;
            break;
         end
      end
   endtask

   // Called in the first pause clock: checks the 8-clock freeze (with stray
   // pulses that must be ignored) and the reload clock back in RUN.
   task automatic pause_window(input string tag, input logic [1:0] st, input logic [3:0] rev);
      check({tag, "_entry_state"}, 32'(o_State), 32'(st));
      check({tag, "_entry_rev"}, 32'(o_Reverse), 32'(rev));
      for (int i = 0; i < 8; i++) begin
         check({tag, "_hold_state"}, 32'(o_State), 32'(st));
         check({tag, "_hold_freeze"}, 32'(o_Freeze), 32'd1);
         check({tag, "_hold_step"}, 32'(o_Step), 32'd0);
         check({tag, "_hold_load"}, 32'(o_Load_Init), 32'd0);
         i_Collision = (i == 3);
         i_Level_Up  = (i == 3);
         i_Start     = (i == 3);
         next_clk();
         i_Collision = 1'b0;
         i_Level_Up  = 1'b0;
         i_Start     = 1'b0;
      end
      check({tag, "_ret_state"}, 32'(o_State), 32'd1);
      check({tag, "_ret_load"}, 32'(o_Load_Init), 32'd1);
      check({tag, "_ret_freeze"}, 32'(o_Freeze), 32'd0);
      check({tag, "_ret_rev"}, 32'(o_Reverse), 32'(rev));
   endtask

   initial begin
      int first1;
      int first3;
      int n0;
      int n1;
      int nl;
      int rev_bad;
      int gap;

      i_Reset     = 1'b1;
      i_Start     = 1'b0;
      i_Score     = 4'd0;
      i_Collision = 1'b0;
      i_Level_Up  = 1'b0;
      repeat (2) next_clk();

      check("rst_state", 32'(o_State), 32'd0);
      check("rst_freeze", 32'(o_Freeze), 32'd1);
      check("rst_step", 32'(o_Step), 32'd0);
      check("rst_rev", 32'(o_Reverse), 32'hA);
      check("rst_load", 32'(o_Load_Init), 32'd0);

      i_Reset     = 1'b0;
      i_Collision = 1'b1;
      next_clk();
      i_Collision = 1'b0;
      check("idle_ignores_coll", 32'(o_State), 32'd0);

      // Start at score 0: period 16.
      i_Start = 1'b1;
      next_clk();
      i_Start = 1'b0;
      check("start_state", 32'(o_State), 32'd1);
      check("start_load", 32'(o_Load_Init), 32'd1);
      check("start_freeze", 32'(o_Freeze), 32'd0);
      check("start_step", 32'(o_Step), 32'd0);

      first1  = 0;
      first3  = 0;
      n0      = 0;
      n1      = 0;
      nl      = 0;
      rev_bad = 0;
      for (int c = 1; c <= 64; c++) begin
         next_clk();
         if (o_Step[1]) begin
            n1++;
            if (first1 == 0) first1 = c;
         end
         if (o_Step[0]) n0++;
         if (o_Step[3] && first3 == 0) first3 = c;
         if (o_Load_Init) nl++;
         if (o_Reverse !== 4'b1010) rev_bad++;
      end
      check("first_step1", 32'(first1), 32'd16);
      check("count_step1", 32'(n1), 32'd4);
      check("count_step0", 32'(n0), 32'd2);
      check("first_step3", 32'(first3), 32'd64);
      check("run_load_quiet", 32'(nl), 32'd0);
      check("run_rev_stable", 32'(rev_bad), 32'd0);

      // Tick counter reaches 12, then the score jumps to tier 4 (period 2).
      repeat (12) next_clk();
      i_Score = 4'd10;
      next_clk();
      check("score_jump_step", 32'(o_Step), 32'h2);
      for (int i = 0; i < 6; i++) begin
         next_clk();
         check("fast_steps", 32'(o_Step), 32'(exp_seq[i]));
      end

      // Collision: freeze, reload, direction unchanged.
      i_Collision = 1'b1;
      next_clk();
      i_Collision = 1'b0;
      pause_window("hit", 2'd2, 4'b1010);
      next_clk();
      check("hit_load_once", 32'(o_Load_Init), 32'd0);
      check("hit_no_early_step", 32'(o_Step), 32'd0);
      next_clk();
      check("hit_first_step", 32'(o_Step), 32'h2);

      // Two level-ups rotate the directions and back.
      i_Level_Up = 1'b1;
      next_clk();
      i_Level_Up = 1'b0;
      pause_window("lvl1", 2'd3, 4'b0101);
      next_clk();
      i_Level_Up = 1'b1;
      next_clk();
      i_Level_Up = 1'b0;
      pause_window("lvl2", 2'd3, 4'b1010);

      // Simultaneous events: collision wins.
      next_clk();
      i_Collision = 1'b1;
      i_Level_Up  = 1'b1;
      next_clk();
      i_Collision = 1'b0;
      i_Level_Up  = 1'b0;
      pause_window("both", 2'd2, 4'b1010);

      // Reset in the middle of a level pause.
      next_clk();
      i_Level_Up = 1'b1;
      next_clk();
      i_Level_Up = 1'b0;
      check("lvl3_state", 32'(o_State), 32'd3);
      check("lvl3_rev", 32'(o_Reverse), 32'h5);
      repeat (3) next_clk();
      i_Reset = 1'b1;
      next_clk();
      i_Reset = 1'b0;
      check("midrst_state", 32'(o_State), 32'd0);
      check("midrst_rev", 32'(o_Reverse), 32'hA);
      check("midrst_load", 32'(o_Load_Init), 32'd0);
      check("midrst_freeze", 32'(o_Freeze), 32'd1);
      check("midrst_step", 32'(o_Step), 32'd0);
      nl = 0;
      for (int i = 0; i < 10; i++) begin
         next_clk();
         if (o_Load_Init || o_State != 2'd0) nl++;
      end
      check("midrst_quiet", 32'(nl), 32'd0);

      // Score tier boundaries measured as step-to-step gaps.
      i_Score = 4'd0;
      i_Start = 1'b1;
      next_clk();
      i_Start = 1'b0;
      measure_gap(gap);
      check("restart_first_step", 32'(gap), 32'd16);
      for (int i = 0; i < 8; i++) begin
         i_Score = 4'(gap_score[i]);
         measure_gap(gap);
         check($sformatf("gap_score_%0d", gap_score[i]), 32'(gap), 32'(gap_exp[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
